// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate reduction self-test driver.
// Holds the sweep FSM state encoding and default sizing constants.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_N_IN       = 3;
  localparam int DEF_SETTLE_CYC = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_vector_driver_ref.sv
// Golden AND/OR reduction of the driven vector.
// Purely combinational; also usable as a scoreboard reference.
module gate_ref_model #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp_and,
  output logic            exp_or
);

  assign exp_and = &vec;
  assign exp_or  = |vec;

endmodule

// File: rtl/gate_vector_driver.sv
// Exhaustive vector sweep driver for 3-input style AND/OR gates.
// Drives each input pattern, waits to settle, checks and tallies.
module gate_vector_driver
  import gate_test_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            and_in,
  input  logic            or_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int CW = clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fval_q, fval_d;
  logic [N_IN-1:0] fvec_q, fvec_d;

  logic exp_and;
  logic exp_or;
  logic mismatch;

  gate_ref_model #(
    .N_IN (N_IN)
  ) u_ref (
    .vec     (vec_q),
    .exp_and (exp_and),
    .exp_or  (exp_or)
  );

  assign mismatch = (and_in != exp_and) | (or_in != exp_or);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fval_d  = fval_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          vec_d   = '0;
          err_d   = '0;
          fval_d  = 1'b0;
          fvec_d  = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fval_q) begin
            fval_d = 1'b1;
            fvec_d = vec_q;
          end
        end
        // Stop on the last pattern so the vector never wraps mid-sweep.
        if (vec_q == LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything but keeps the error record.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      vec_d   = '0;
      err_d   = err_q;
      fval_d  = fval_q;
      fvec_d  = fvec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fval_q  <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fval_q  <= fval_d;
      fvec_q  <= fvec_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fval_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_vector_driver.sv
// Bench for gate_vector_driver: fault-injectable fake gate,
// arithmetic reference of sweep results, directed plus random sweeps.
module tb_gate_vector_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] vec_out;
  logic       and_in, or_in;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] fail_vec;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic [0:0] vec1;
  logic       and1, or1;
  logic       busy1, done1, pass1;
  logic [1:0] err1;
  logic       fval1;
  logic [0:0] fvec1;

  bit [1:0] flip [8];
  bit       and_stuck0 = 1'b0;
  bit       or_stuck1  = 1'b0;

  int checks = 0;
  int errors = 0;

  always_comb begin
    and_in = and_stuck0 ? 1'b0 : ((&vec_out) ^ flip[vec_out][0]);
    or_in  = or_stuck1  ? 1'b1 : ((|vec_out) ^ flip[vec_out][1]);
  end

  assign and1 = vec1[0];
  assign or1  = vec1[0];

  gate_vector_driver #(.N_IN(3), .SETTLE_CYC(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .vec_out    (vec_out),
    .and_in     (and_in),
    .or_in      (or_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  gate_vector_driver #(.N_IN(1), .SETTLE_CYC(3)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .abort      (abort1),
    .vec_out    (vec1),
    .and_in     (and1),
    .or_in      (or1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .fail_valid (fval1),
    .fail_vec   (fvec1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected error count and first failing vector over the first n vectors.
  function automatic void model(input int n, output int e, output int f);
    e = 0;
    f = -1;
    for (int v = 0; v < n; v++) begin
      int ia, io, a, o;
      ia = (v == 7) ? 1 : 0;
      io = (v != 0) ? 1 : 0;
      a  = and_stuck0 ? 0 : (ia ^ int'(flip[v][0]));
      o  = or_stuck1  ? 1 : (io ^ int'(flip[v][1]));
      if (a != ia || o != io) begin
        e++;
        if (f < 0) f = v;
      end
    end
  endfunction

  task automatic clear_faults();
    and_stuck0 = 1'b0;
    or_stuck1  = 1'b0;
    for (int v = 0; v < 8; v++) flip[v] = 2'b00;
  endtask

  task automatic rand_faults();
    clear_faults();
    for (int v = 0; v < 8; v++) begin
      if ($urandom_range(0, 2) == 0) flip[v] = 2'($urandom_range(1, 3));
    end
  endtask

  task automatic sweep(input string tag, input bit mid_start);
    int t, e, f;
    bit vbad;
    model(8, e, f);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    t = 0;
    vbad = 1'b0;
    while (done !== 1'b1 && t < 200) begin
      if (vec_out !== 3'(t / 2)) vbad = 1'b1;
      start = mid_start && (t == 5);
      tick();
      t++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, t, 16);
    chk({tag, "_vec_seq"}, vbad, 0);
    chk({tag, "_err_count"}, err_count, e);
    chk({tag, "_fail_valid"}, fail_valid, (f >= 0));
    chk({tag, "_fail_vec"}, fail_vec, (f >= 0) ? f : 0);
    tick();
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_pass"}, pass, (e == 0));
    chk({tag, "_vec_hold"}, vec_out, 7);
  endtask

  initial begin
    int e, f, t;
    bit seen, bad;
    clear_faults();
    #12;
    chk("rst_vec", vec_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fval", fail_valid, 0);
    chk("rst_fvec", fail_vec, 0);
    rst_n = 1'b1;
    tick();
    tick();

    sweep("clean", 1'b0);

    clear_faults();
    and_stuck0 = 1'b1;
    sweep("and_sa0", 1'b0);

    clear_faults();
    or_stuck1 = 1'b1;
    sweep("or_sa1", 1'b0);

    for (int i = 0; i < 3; i++) begin
      rand_faults();
      sweep($sformatf("rand%0d", i), 1'b0);
    end

    clear_faults();
    sweep("mid_start", 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0) seen = 1'b1;
    end
    chk("no_restart", seen, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);
    tick();
    chk("start_abort_idle_busy2", busy, 0);

    rand_faults();
    flip[0] = 2'b10;
    model(2, e, f);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vec", vec_out, 0);
    chk("abort_pass", pass, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err_count, e);
    chk("abort_fval", fail_valid, (f >= 0));
    chk("abort_fvec", fail_vec, (f >= 0) ? f : 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("abort_quiet", seen, 0);
    clear_faults();
    sweep("post_abort", 1'b0);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t = 0;
    bad = 1'b0;
    while (done1 !== 1'b1 && t < 100) begin
      if (vec1 !== 1'(t / 4)) bad = 1'b1;
      tick();
      t++;
    end
    chk("n1_latency", t, 8);
    chk("n1_vec_seq", bad, 0);
    tick();
    chk("n1_pass", pass1, 1);
    chk("n1_err", err1, 0);
    chk("n1_busy", busy1, 0);

    clear_faults();
    flip[0] = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_err", err_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", vec_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pass", pass, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_fval", fail_valid, 0);
    chk("mid_rst_fvec", fail_vec, 0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
